step_alt_sequencer: RTL and testbench
=====================================

// Module: step_alt_sequencer
// PURPOSE
//  FSM sequencer that drives an 8-bit result register through alternating
//  increment/decrement steps, one step per clock edge.
//  Replaces the illegal multi-event-control always_ff idiom with one legal
//  single-edge FSM.
//  Sits between a test/stimulus master (start/operand select) and the y datapath.
//  Issues a start/busy/done handshake and a per-step valid strobe.
// PARAMETERS
//  W         8   datapath width of a, b, y
//  CNT_W     3   width of nsteps / internal step counter
//  INC_STEP  2   amount added in an INC step (mod 2^W)
//  DEC_STEP  1   amount subtracted in a DEC step (mod 2^W)
// PORTS
//  clk      in   1      single clock, all state on posedge
//  rstn     in   1      asynchronous active-low reset
//  start    in   1      request a run; sampled only in IDLE
//  abort    in   1      terminate current run; sampled in INC/DEC
//  sel      in   1      operand select at start: 0 -> a, 1 -> b
//  a        in   W      operand 0
//  b        in   W      operand 1
//  nsteps   in   CNT_W  step count; 0 encodes 2^CNT_W steps
//  y        out  W      result register
//  y_valid  out  1      1-cycle strobe: y updated by a step this cycle
//  busy     out  1      high from cycle after accepted start until DONE
//  done     out  1      1-cycle pulse in DONE state
//  phase    out  1      next step type: 1 = INC, 0 = DEC
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - state=IDLE; y=0, y_valid=0, busy=0, done=0, phase=1, cnt=0.
//  States: IDLE, INC, DEC, DONE (registered, one always_ff, single posedge/negedge-rstn event).
//  IDLE:
//   - on start=1: y<=(sel?b:a), cnt<=nsteps, busy<=1, phase<=1, state<=INC.
//   - y_valid=0 on the load.
//  INC:
//   - y<=y+INC_STEP (wraps mod 2^W), y_valid<=1, cnt<=cnt-1, phase<=0.
//   - next state: DONE if cnt==1, else DEC.
//  DEC:
//   - y<=y-DEC_STEP (wraps mod 2^W), y_valid<=1, cnt<=cnt-1, phase<=1.
//   - next state: DONE if cnt==1, else INC.
//  Counter: nsteps=0 loads cnt=0; the decrement wraps, giving exactly 2^CNT_W steps.
//  DONE:
//   - done<=1 for exactly one cycle, busy<=0, y held, state<=IDLE.
//  Latency: load at edge 0; first step lands at edge 1; done at edge N+1.
//  abort=1 in INC/DEC: no step taken, y held, state<=DONE (done still pulses).
//  start while busy or in DONE: ignored, no queuing.
//  start and abort both high in IDLE: start wins (abort ignored in IDLE).
//  Operand inputs a/b/sel: sampled only at load; later changes have no effect.
//  Reset mid-run: immediate return to reset values; no done pulse.
//  Arithmetic: unsigned W-bit, carry/borrow discarded, no saturation.
// STRUCTURE
//  Package step_seq_pkg:
//   - typedef enum logic [1:0] {IDLE, INC, DEC, DONE} seq_state_t
//   - default step constants
//  Single module, no sub-module: FSM, counter and y register in one always_ff.
//  Next-state logic in one always_comb.
// TESTING
//  1. a=1, sel=0, nsteps=4 -> y: 1,3,2,4,3 on edges 0..4; done at edge 5; final y=3.
//  2. b=8'hFE, sel=1, nsteps=1 -> y=FE then 00 (wrap); exactly one y_valid; done next.
//  3. a=1, nsteps=0 -> 8 steps, y ends 5; exactly 8 y_valid strobes.
//  4. abort after 2nd step (a=1, nsteps=6) -> y frozen at 2; done pulses; busy drops.
//  5. start re-asserted while busy with a=9 -> ignored; run completes with original operand.
//  6. rstn=0 mid-run (async, between edges) -> y=0, busy=0 immediately; no done; next start works.

Source files
------------

// File: rtl/step_seq_pkg.sv
// Shared state encoding and default step constants for the alternating
// increment/decrement sequencer.
package step_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam int DEF_W        = 8;
    localparam int DEF_CNT_W    = 3;
    localparam int DEF_INC_STEP = 2;
    localparam int DEF_DEC_STEP = 1;

endpackage

// File: rtl/step_alt_sequencer.sv
// Sequencer that loads an operand and then walks y through alternating
// +INC_STEP / -DEC_STEP steps, one per clock, with start/busy/done handshake.
module step_alt_sequencer
    import step_seq_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int INC_STEP = DEF_INC_STEP,
    parameter int DEC_STEP = DEF_DEC_STEP
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic             sel,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [CNT_W-1:0] nsteps,
    output logic [W-1:0]     y,
    output logic             y_valid,
    output logic             busy,
    output logic             done,
    output logic             phase
);

    localparam logic [W-1:0]     INC_V = W'(INC_STEP);
    localparam logic [W-1:0]     DEC_V = W'(DEC_STEP);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [W-1:0]     y_nxt;
    logic             y_valid_nxt, busy_nxt, done_nxt, phase_nxt;

    // cnt==1 marks the last step; a zero load wraps through all 2^CNT_W values.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        y_nxt       = y;
        y_valid_nxt = 1'b0;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        phase_nxt   = phase;
        case (state)
            IDLE: begin
                if (start) begin
                    y_nxt     = sel ? b : a;
                    cnt_nxt   = nsteps;
                    busy_nxt  = 1'b1;
                    phase_nxt = 1'b1;
                    state_nxt = INC;
                end
            end
            INC: begin
                if (abort) begin
                    state_nxt = DONE;
                end else begin
                    y_nxt       = y + INC_V;
                    y_valid_nxt = 1'b1;
                    cnt_nxt     = cnt - ONE;
                    phase_nxt   = 1'b0;
                    state_nxt   = (cnt == ONE) ? DONE : DEC;
                end
            end
            DEC: begin
                if (abort) begin
                    state_nxt = DONE;
                end else begin
                    y_nxt       = y - DEC_V;
                    y_valid_nxt = 1'b1;
                    cnt_nxt     = cnt - ONE;
                    phase_nxt   = 1'b1;
                    state_nxt   = (cnt == ONE) ? DONE : INC;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            phase   <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            y       <= y_nxt;
            y_valid <= y_valid_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            phase   <= phase_nxt;
        end
    end

endmodule

// File: tb/tb_step_alt_sequencer.sv
// Directed bench for step_alt_sequencer with hand-computed expectations.
module tb_step_alt_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start, abort, sel;
    logic [7:0] a, b;
    logic [2:0] nsteps;
    logic [7:0] y;
    logic       y_valid, busy, done, phase;

    int checks   = 0;
    int failures = 0;

    step_alt_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .sel(sel),
        .a(a), .b(b), .nsteps(nsteps), .y(y), .y_valid(y_valid),
        .busy(busy), .done(done), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load an operand: leaves the bench just after the load edge (edge 0).
    task automatic launch(input logic s, input logic [7:0] av, input logic [7:0] bv,
                          input logic [2:0] n);
        sel = s; a = av; b = bv; nsteps = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run until done with a cycle budget, counting y_valid strobes on the way.
    task automatic run_to_done(input string tag, input int exp_strobes, input logic [7:0] exp_y);
        int  strobes = 0;
        bit  seen    = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (y_valid) strobes++;
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_strobes"}, 32'(strobes), 32'(exp_strobes));
        chk({tag, "_final_y"}, 32'(y), 32'(exp_y));
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [7:0] exp1 [4];
        logic       ph1  [4];
        exp1 = '{8'd3, 8'd2, 8'd4, 8'd3};
        ph1  = '{1'b0, 1'b1, 1'b0, 1'b1};

        rstn = 1'b0; start = 0; abort = 0; sel = 0; a = 0; b = 0; nsteps = 0;
        #12;
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(y_valid), 32'd0);
        chk("rst_phase", 32'(phase), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // 1: a=1, 4 steps -> 1,3,2,4,3
        launch(1'b0, 8'd1, 8'd0, 3'd4);
        chk("t1_load_y", 32'(y), 32'd1);
        chk("t1_load_valid", 32'(y_valid), 32'd0);
        chk("t1_load_busy", 32'(busy), 32'd1);
        chk("t1_load_phase", 32'(phase), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t1_y_e%0d", i + 1), 32'(y), 32'(exp1[i]));
            chk($sformatf("t1_valid_e%0d", i + 1), 32'(y_valid), 32'd1);
            chk($sformatf("t1_phase_e%0d", i + 1), 32'(phase), 32'(ph1[i]));
            chk($sformatf("t1_nodone_e%0d", i + 1), 32'(done), 32'd0);
        end
        tick();
        chk("t1_done_e5", 32'(done), 32'd1);
        chk("t1_busy_e5", 32'(busy), 32'd0);
        chk("t1_y_e5", 32'(y), 32'd3);
        chk("t1_valid_e5", 32'(y_valid), 32'd0);
        tick();
        chk("t1_done_drop", 32'(done), 32'd0);

        // 2: b=FE, 1 step -> wraps to 00
        launch(1'b1, 8'h55, 8'hFE, 3'd1);
        chk("t2_load_y", 32'(y), 32'hFE);
        run_to_done("t2", 1, 8'h00);

        // 3: nsteps=0 -> 8 steps, ends at 5
        launch(1'b0, 8'd1, 8'd0, 3'd0);
        run_to_done("t3", 8, 8'd5);

        // 4: abort after second step freezes y at 2
        launch(1'b0, 8'd1, 8'd0, 3'd6);
        tick();
        tick();
        chk("t4_y_pre", 32'(y), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_y_held", 32'(y), 32'd2);
        chk("t4_no_valid", 32'(y_valid), 32'd0);
        chk("t4_busy_still", 32'(busy), 32'd1);
        tick();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy_drop", 32'(busy), 32'd0);
        chk("t4_y_final", 32'(y), 32'd2);
        tick();

        // 5: start while busy is ignored; operand changes ignored
        launch(1'b0, 8'd3, 8'd0, 3'd2);
        a = 8'd9; sel = 1'b1; b = 8'd77; start = 1'b1;
        tick();
        chk("t5_e1_y", 32'(y), 32'd5);
        tick();
        chk("t5_e2_y", 32'(y), 32'd4);
        start = 1'b0;
        tick();
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_final_y", 32'(y), 32'd4);
        tick();

        // 6: async reset mid-run
        launch(1'b0, 8'd7, 8'd0, 3'd5);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_y", 32'(y), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_phase", 32'(phase), 32'd1);
        begin
            int dones = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (done) dones++;
            end
            chk("t6_no_done", 32'(dones), 32'd0);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        launch(1'b0, 8'd1, 8'd0, 3'd1);
        chk("t6_restart_load", 32'(y), 32'd1);
        run_to_done("t6r", 1, 8'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
